// File: rtl/m65c02_reg_file_pkg.sv
// Shared encodings and constants for the M65C02A architectural register file.
// Optional 3-level register stacks are enabled by the REG_STACK_EN macro.
package m65c02_reg_file_pkg;

  typedef enum logic [1:0] {
    STK_HOLD = 2'b00,
    STK_PUSH = 2'b01,
    STK_PULL = 2'b10,
    STK_NOP  = 2'b11
  } stk_op_t;

  typedef enum logic [1:0] {
    RS_NONE = 2'b00,
    RS_DUP  = 2'b01,
    RS_SWP  = 2'b10,
    RS_ROT  = 2'b11
  } rs_op_t;

  typedef enum logic [1:0] {
    RS_SEL_A    = 2'b00,
    RS_SEL_X    = 2'b01,
    RS_SEL_Y    = 2'b10,
    RS_SEL_NONE = 2'b11
  } rs_sel_t;

  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_D = 3;
  localparam int P_I = 2;
  localparam int P_Z = 1;
  localparam int P_C = 0;

  // Bits 5 and 4 have no storage; they always read back as 1.
  localparam logic [7:0] P_STORE_MASK = 8'((1 << P_N) | (1 << P_V) | (1 << P_D) |
                                           (1 << P_I) | (1 << P_Z) | (1 << P_C));
  localparam logic [7:0] P_FIXED_ONES = ~P_STORE_MASK;

  localparam logic [7:0] S_RST  = 8'hFF;
  localparam logic [7:0] P_RST  = 8'h34;
  localparam logic [7:0] STK_PG = 8'h01;

endpackage

// File: rtl/m65c02_reg_file_if.sv
// Control/result bundle between the write-select decoder/ALU and the register file.
interface m65c02_reg_file_if;
  import m65c02_reg_file_pkg::*;

  logic        Rdy;
  logic        SelA;
  logic        SelX;
  logic        SelY;
  logic        SelP;
  logic        SelS;
  logic [7:0]  Out;
  logic [7:0]  PSW_In;
  stk_op_t     Stk_Op;
  logic        Int_Ack;
  rs_sel_t     RS_Sel;
  rs_op_t      RS_Op;

  logic [7:0]  A;
  logic [7:0]  X;
  logic [7:0]  Y;
  logic [7:0]  S;
  logic [7:0]  P;
  logic [15:0] Stk_Addr;

  modport master (
    output Rdy, SelA, SelX, SelY, SelP, SelS, Out, PSW_In, Stk_Op, Int_Ack, RS_Sel, RS_Op,
    input  A, X, Y, S, P, Stk_Addr
  );

  modport slave (
    input  Rdy, SelA, SelX, SelY, SelP, SelS, Out, PSW_In, Stk_Op, Int_Ack, RS_Sel, RS_Op,
    output A, X, Y, S, P, Stk_Addr
  );

endinterface

// File: rtl/m65c02_reg_stk.sv
// One 8-bit register; with REG_STACK_EN it becomes a 3-level stack {TOS, NOS, BOS}.
// One-cycle write latency; all updates stall while Rdy is low.
module m65c02_reg_stk
  import m65c02_reg_file_pkg::*;
(
  input  logic       Clk,
  input  logic       nRst,
  input  logic       Rdy,
  input  logic       WE,
  input  logic [7:0] D,
  input  rs_op_t     Op,
  input  logic       En,
  output logic [7:0] TOS
);

`ifdef REG_STACK_EN
  logic [7:0] nos;
  logic [7:0] bos;
  logic [7:0] tos_n;
  logic [7:0] nos_n;
  logic [7:0] bos_n;

  always_comb begin
    tos_n = TOS;
    nos_n = nos;
    bos_n = bos;
    if (En) begin
      case (Op)
        RS_DUP: begin
          bos_n = nos;
          nos_n = TOS;
        end
        RS_SWP: begin
          tos_n = nos;
          nos_n = TOS;
        end
        RS_ROT: begin
          tos_n = nos;
          nos_n = bos;
          bos_n = TOS;
        end
        default: ;
      endcase
    end
    // A write only replaces the new TOS; lower levels still follow the stack op.
    if (WE) begin
      tos_n = D;
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      TOS <= 8'h00;
      nos <= 8'h00;
      bos <= 8'h00;
    end else if (Rdy) begin
      TOS <= tos_n;
      nos <= nos_n;
      bos <= bos_n;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{Op, En};

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      TOS <= 8'h00;
    end else if (Rdy && WE) begin
      TOS <= D;
    end
  end
`endif

endmodule

// File: rtl/m65c02_reg_file.sv
// M65C02A architectural register file: A/X/Y (optionally 3-deep via REG_STACK_EN), S and P.
// Writes land one cycle after a Sel* strobe; Rdy=0 freezes all state; Stk_Addr is combinational.
module m65c02_reg_file
  import m65c02_reg_file_pkg::*;
#(
  parameter logic [7:0] pS_Rst = S_RST,
  parameter logic [7:0] pP_Rst = P_RST,
  parameter logic [7:0] pStkPg = STK_PG
) (
  input  logic             Clk,
  input  logic             nRst,
  m65c02_reg_file_if.slave bus
);

  logic [7:0] a_tos;
  logic [7:0] x_tos;
  logic [7:0] y_tos;
  logic       en_a;
  logic       en_x;
  logic       en_y;

  assign en_a = (bus.RS_Sel == RS_SEL_A);
  assign en_x = (bus.RS_Sel == RS_SEL_X);
  assign en_y = (bus.RS_Sel == RS_SEL_Y);

  m65c02_reg_stk u_stk_a (
    .Clk  (Clk),
    .nRst (nRst),
    .Rdy  (bus.Rdy),
    .WE   (bus.SelA),
    .D    (bus.Out),
    .Op   (bus.RS_Op),
    .En   (en_a),
    .TOS  (a_tos)
  );

  m65c02_reg_stk u_stk_x (
    .Clk  (Clk),
    .nRst (nRst),
    .Rdy  (bus.Rdy),
    .WE   (bus.SelX),
    .D    (bus.Out),
    .Op   (bus.RS_Op),
    .En   (en_x),
    .TOS  (x_tos)
  );

  m65c02_reg_stk u_stk_y (
    .Clk  (Clk),
    .nRst (nRst),
    .Rdy  (bus.Rdy),
    .WE   (bus.SelY),
    .D    (bus.Out),
    .Op   (bus.RS_Op),
    .En   (en_y),
    .TOS  (y_tos)
  );

  logic [7:0] s_q;
  logic [7:0] s_n;
  logic [7:0] s_inc;
  logic [7:0] p_q;
  logic [7:0] p_n;

  assign s_inc = s_q + 8'd1;

  always_comb begin
    s_n = s_q;
    if (bus.SelS) begin
      s_n = bus.Out;
    end else begin
      case (bus.Stk_Op)
        STK_PUSH: s_n = s_q - 8'd1;
        STK_PULL: s_n = s_inc;
        default:  s_n = s_q;
      endcase
    end
  end

  always_comb begin
    p_n = p_q;
    if (bus.SelP) begin
      p_n = bus.PSW_In & P_STORE_MASK;
    end
    // Vector fetch wins over the flag logic for I and D.
    if (bus.Int_Ack) begin
      p_n[P_I] = 1'b1;
      p_n[P_D] = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      s_q <= pS_Rst;
      p_q <= pP_Rst & P_STORE_MASK;
    end else if (bus.Rdy) begin
      s_q <= s_n;
      p_q <= p_n;
    end
  end

  assign bus.A        = a_tos;
  assign bus.X        = x_tos;
  assign bus.Y        = y_tos;
  assign bus.S        = s_q;
  assign bus.P        = p_q | P_FIXED_ONES;
  assign bus.Stk_Addr = {pStkPg, (bus.Stk_Op == STK_PULL) ? s_inc : s_q};

endmodule

// File: tb/tb_m65c02_reg_file.sv
// Scoreboard bench for m65c02_reg_file: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_m65c02_reg_file;
  import m65c02_reg_file_pkg::*;

  logic Clk = 1'b0;
  logic nRst;
  always #5 Clk = ~Clk;

  m65c02_reg_file_if bus ();

  m65c02_reg_file dut (
    .Clk  (Clk),
    .nRst (nRst),
    .bus  (bus)
  );

  typedef struct {
    bit          is_addr;
    string       name;
    logic [39:0] regs;
    logic [15:0] addr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic exp_regs(input string n, input logic [7:0] a, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] s, input logic [7:0] p);
    exp_t e;
    e.is_addr = 1'b0;
    e.name    = n;
    e.regs    = {a, x, y, s, p};
    e.addr    = 16'h0;
    q.push_back(e);
  endtask

  task automatic exp_addr(input string n, input logic [15:0] ad);
    exp_t e;
    e.is_addr = 1'b1;
    e.name    = n;
    e.regs    = 40'h0;
    e.addr    = ad;
    q.push_back(e);
  endtask

  task automatic clear_ctl();
    bus.Rdy     = 1'b1;
    bus.SelA    = 1'b0;
    bus.SelX    = 1'b0;
    bus.SelY    = 1'b0;
    bus.SelP    = 1'b0;
    bus.SelS    = 1'b0;
    bus.Stk_Op  = STK_HOLD;
    bus.Int_Ack = 1'b0;
    bus.RS_Sel  = RS_SEL_NONE;
    bus.RS_Op   = RS_NONE;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    clear_ctl();
  endtask

  // Monitor: outputs are stable at the falling edge, so check everything queued.
  always @(negedge Clk) begin
    exp_t        e;
    logic [39:0] got;
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (e.is_addr) begin
        if (bus.Stk_Addr !== e.addr) begin
          bad++;
          $display("FAIL %s: Stk_Addr got %h want %h", e.name, bus.Stk_Addr, e.addr);
        end
      end else begin
        got = {bus.A, bus.X, bus.Y, bus.S, bus.P};
        if (got !== e.regs) begin
          bad++;
          $display("FAIL %s: A/X/Y/S/P got %h want %h", e.name, got, e.regs);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst       = 1'b0;
    bus.Out    = 8'h00;
    bus.PSW_In = 8'h00;
    clear_ctl();
    exp_regs("reset_state", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h34);
    exp_addr("reset_addr", 16'h01FF);
    @(negedge Clk);
    #1 nRst = 1'b1;
    @(posedge Clk);
    #1;

    // Stack pointer wrap and push/pull addressing
    bus.Stk_Op = STK_PUSH;
    exp_addr("push_addr_ff", 16'h01FF);
    tick();
    exp_regs("push_s_fe", 8'h00, 8'h00, 8'h00, 8'hFE, 8'h34);

    bus.SelS = 1'b1; bus.Out = 8'h00;
    tick();
    exp_regs("sel_s_00", 8'h00, 8'h00, 8'h00, 8'h00, 8'h34);

    bus.Stk_Op = STK_PUSH;
    exp_addr("push_addr_00", 16'h0100);
    tick();
    exp_regs("push_wrap_ff", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h34);

    bus.Stk_Op = STK_PULL;
    exp_addr("pull_addr_wrap", 16'h0100);
    tick();
    exp_regs("pull_wrap_00", 8'h00, 8'h00, 8'h00, 8'h00, 8'h34);

    // SelS beats a same-cycle pull
    bus.SelS = 1'b1; bus.Out = 8'h80; bus.Stk_Op = STK_PULL;
    exp_addr("pull_addr_01", 16'h0101);
    tick();
    exp_regs("sel_s_prio", 8'h00, 8'h00, 8'h00, 8'h80, 8'h34);

    // Rdy low freezes everything
    bus.Rdy = 1'b0; bus.SelS = 1'b1; bus.SelA = 1'b1; bus.Out = 8'h11;
    bus.Stk_Op = STK_PULL; bus.SelP = 1'b1; bus.PSW_In = 8'hFF; bus.Int_Ack = 1'b1;
    tick();
    exp_regs("rdy_hold", 8'h00, 8'h00, 8'h00, 8'h80, 8'h34);

    // PSW handling
    bus.SelP = 1'b1; bus.PSW_In = 8'hC3;
    tick();
    exp_regs("psw_c3", 8'h00, 8'h00, 8'h00, 8'h80, 8'hF3);

    bus.SelP = 1'b1; bus.PSW_In = 8'h0C; bus.Int_Ack = 1'b1;
    tick();
    exp_regs("psw_int_ack", 8'h00, 8'h00, 8'h00, 8'h80, 8'h34);

    bus.SelP = 1'b1; bus.PSW_In = 8'hCB;
    tick();
    exp_regs("psw_cb", 8'h00, 8'h00, 8'h00, 8'h80, 8'hFB);

    bus.Int_Ack = 1'b1;
    tick();
    exp_regs("int_ack_only", 8'h00, 8'h00, 8'h00, 8'h80, 8'hF7);

    // Parallel writes
    bus.SelA = 1'b1; bus.SelX = 1'b1; bus.SelY = 1'b1; bus.Out = 8'h7E;
    tick();
    exp_regs("parallel_7e", 8'h7E, 8'h7E, 8'h7E, 8'h80, 8'hF7);

    bus.SelX = 1'b1; bus.Out = 8'hA5; bus.Stk_Op = STK_PUSH;
    exp_addr("push_addr_80", 16'h0180);
    tick();
    exp_regs("x_and_push", 8'h7E, 8'hA5, 8'h7E, 8'h7F, 8'hF7);

    // Asynchronous reset mid-cycle with a write pending
    @(negedge Clk);
    #1;
    bus.SelA = 1'b1; bus.Out = 8'h55;
    #2 nRst = 1'b0;
    exp_regs("async_reset", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h34);
    @(negedge Clk);
    #1;
    bus.SelA = 1'b0;
    nRst = 1'b1;
    @(posedge Clk);
    #1;
    exp_regs("post_release", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h34);

    bus.SelA = 1'b1; bus.Out = 8'h3C;
    tick();
    exp_regs("write_after_rst", 8'h3C, 8'h00, 8'h00, 8'hFF, 8'h34);

`ifdef REG_STACK_EN
    // Build A stack 11/22/33 via DUP+write, then exercise ROT/SWP/DUP
    bus.SelA = 1'b1; bus.Out = 8'h33; bus.RS_Sel = RS_SEL_A; bus.RS_Op = RS_DUP;
    tick();
    bus.SelA = 1'b1; bus.Out = 8'h22; bus.RS_Sel = RS_SEL_A; bus.RS_Op = RS_DUP;
    tick();
    bus.SelA = 1'b1; bus.Out = 8'h11; bus.RS_Sel = RS_SEL_A; bus.RS_Op = RS_DUP;
    tick();
    exp_regs("rs_load", 8'h11, 8'h00, 8'h00, 8'hFF, 8'h34);

    bus.RS_Sel = RS_SEL_A; bus.RS_Op = RS_ROT;
    tick();
    exp_regs("rs_rot", 8'h22, 8'h00, 8'h00, 8'hFF, 8'h34);

    bus.RS_Sel = RS_SEL_A; bus.RS_Op = RS_SWP;
    tick();
    exp_regs("rs_swp", 8'h33, 8'h00, 8'h00, 8'hFF, 8'h34);

    bus.SelA = 1'b1; bus.Out = 8'h99; bus.RS_Sel = RS_SEL_A; bus.RS_Op = RS_DUP;
    tick();
    exp_regs("rs_dup_write", 8'h99, 8'h00, 8'h00, 8'hFF, 8'h34);

    bus.RS_Sel = RS_SEL_A; bus.RS_Op = RS_SWP;
    tick();
    exp_regs("rs_swp_nos", 8'h33, 8'h00, 8'h00, 8'hFF, 8'h34);

    bus.RS_Sel = RS_SEL_A; bus.RS_Op = RS_ROT;
    tick();
    exp_regs("rs_rot_bos", 8'h99, 8'h00, 8'h00, 8'hFF, 8'h34);

    bus.RS_Sel = RS_SEL_NONE; bus.RS_Op = RS_ROT;
    tick();
    exp_regs("rs_sel_none", 8'h99, 8'h00, 8'h00, 8'hFF, 8'h34);
`else
    // Stack controls must be ignored when the register stacks are absent
    bus.RS_Sel = RS_SEL_A; bus.RS_Op = RS_ROT;
    tick();
    exp_regs("rs_ignored", 8'h3C, 8'h00, 8'h00, 8'hFF, 8'h34);
`endif

    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      @(posedge Clk);
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m65c02_reg_file.md
Name: m65c02_reg_file

Overview:
Architectural register file for the M65C02A core, directly downstream of the write-select decoder.
- Consumes the SelA/SelX/SelY/SelP/SelS strobes and the ALU result.
- Holds A, X, Y, S and P, and advances S for push/pull.
- Drives the register operands back to the ALU and the stack address to the address generator.

Parameters:
pS_Rst, 8'hFF, reset value of stack pointer S
pP_Rst, 8'h34, reset value of P (I=1, D=0, bits 5/4 set)
pStkPg, 8'h01, high byte of stack address

Ports:
Clk  input  1  system clock, all state updates on rising edge
nRst  input  1  asynchronous active-low reset
Rdy  input  1  cycle advance; when 0 all state holds
SelA  input  1  write A from Out
SelX  input  1  write X from Out
SelY  input  1  write Y from Out
SelP  input  1  write P from PSW_In
SelS  input  1  write S from Out
Out  input  8  ALU result
PSW_In  input  8  next PSW from ALU flag logic
Stk_Op  input  2  00 hold, 01 push (post-decrement), 10 pull (pre-increment), 11 hold
Int_Ack  input  1  interrupt/BRK vector fetch: set I, clear D
RS_Sel  input  2  register-stack target: 00 A, 01 X, 10 Y, 11 none (REG_STACK_EN only)
RS_Op  input  2  00 none, 01 DUP, 10 SWP, 11 ROT (REG_STACK_EN only)
A  output  8  accumulator (TOS)
X  output  8  index X (TOS)
Y  output  8  index Y (TOS)
S  output  8  stack pointer
P  output  8  PSW, bits 5 and 4 always read 1
Stk_Addr  output  16  combinational stack address

Behaviour:
- Clock and reset: Clk rising edge. nRst is asynchronous and active-low.
- Reset values: A=X=Y=0, all stack levels 0, S=pS_Rst, P=pP_Rst. Reset mid-operation discards pending writes immediately.
- Rdy gating: every update is qualified by Rdy. With Rdy=0, outputs hold regardless of Sel*, Stk_Op and Int_Ack.
- Write latency: a Sel* strobe sampled high with Rdy=1 updates its register at that edge. The new value is visible on the output after the edge, so one-cycle latency.
- Stk_Addr:
  - Stk_Op=10: {pStkPg, S+1}.
  - Otherwise: {pStkPg, S}.
  - The addition wraps mod 256.
- Stack pointer:
  - Push: S <= S-1, FF follows 00.
  - Pull: S <= S+1, 00 follows FF.
  - SelS has priority over Stk_Op in the same cycle: S <= Out, and the push/pull is ignored.
- PSW:
  - P bits 5 and 4 are not stored; they are forced 1 on output.
  - SelP loads PSW_In except bits 5 and 4.
  - Int_Ack applies after SelP in the same cycle: I=1, D=0, overriding PSW_In bits 2 and 3.
- Simultaneous strobes: multiple Sel* may be asserted together, and each target updates independently.

Optional Feature:
Macro REG_STACK_EN.
- Defined:
  - A, X and Y are each a 3-level stack {TOS, NOS, BOS}; output = TOS.
  - RS_Op acts on the stack chosen by RS_Sel when Rdy=1:
    - DUP: BOS<=NOS, NOS<=TOS.
    - SWP: TOS<=NOS, NOS<=TOS.
    - ROT: TOS<=NOS, NOS<=BOS, BOS<=TOS.
  - A same-cycle Sel* write to that register overrides the TOS result only. NOS/BOS still follow RS_Op.
  - RS_Sel=11 or RS_Op=00: no stack movement.
- Undefined: single 8-bit registers only; RS_Sel and RS_Op are ignored.

Decomposition:
- Shared package: Stk_Op encodings, RS_Op encodings, RS_Sel encodings, P bit indices (N=7, V=6, D=3, I=2, Z=1, C=0), reset constants.
- Natural sub-module: m65c02_reg_stk. It holds one 8-bit 3-level stack, with inputs Clk, nRst, Rdy, WE, D, Op, En and output TOS. It is instantiated three times under REG_STACK_EN, or degenerates to a plain register otherwise.

Test Plan:
- Reset: drop nRst asynchronously mid-cycle with SelA=1, Out=8'h55 -> A=00, S=FF, P=34 immediately; A stays 00 after release until the next write.
- Stack wrap:
  - From reset, Stk_Op=01 with Rdy=1 -> Stk_Addr=0x01FF, then S=FE.
  - Set S=00 via SelS/Out=00, push -> S=FF.
  - Pull from FF -> Stk_Addr=0x0100, S=00.
- Priority and Rdy:
  - SelS=1, Out=8'h80, Stk_Op=10 same cycle -> S=80.
  - Repeat with Rdy=0 -> S unchanged.
- PSW:
  - SelP=1, PSW_In=8'h0C, Int_Ack=1 -> P=8'h34 (I=1, D=0, bits 5/4 forced).
  - SelP alone with PSW_In=8'hC3 -> P=8'hF3.
- Parallel writes: SelA=SelX=SelY=1, Out=8'h7E -> A=X=Y=7E in one edge; P unchanged.
- Register stack (REG_STACK_EN):
  - A TOS/NOS/BOS=11/22/33, ROT -> 22/33/11; SWP -> 33/22/11.
  - DUP with SelA=1, Out=8'h99 -> 99/33/22.
